if_fetch: RTL and testbench

//  Instruction-fetch initiator for the synchronous instruction memory (im).
//  - Drives im address, absorbs the one-cycle read latency, and buffers returned words.
//  - Presents the buffered words to decode with a valid/ready handshake.
//  - Handles pipeline redirects (branch/jump/exception) by flushing buffered and in-flight fetches.

---
 rtl/cpu_defs.sv | 17 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/if_fetch.sv | 78 +++++++
 tb/tb_if_fetch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
`timescale 1ns/1ps
// Shared CPU constants and the fetch buffer entry layout.
// No logic; no latency; no backpressure.
// Imported by the fetch path and its buffer.
package cpu_defs;
  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h9FC0_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
`timescale 1ns/1ps
// Synchronous FIFO of {pc, data} fetch entries with a flush that beats push/pop.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: the caller keeps push off when full; head is all-zero when empty.
module fetch_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic           do_push, do_pop, empty, full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/if_fetch.sv
`timescale 1ns/1ps
// Instruction-fetch initiator: issues im reads, buffers returns, hands words to decode.
// Latency: an issue in cycle N reaches inst_* in cycle N+2; one word per cycle steady state.
// Backpressure: issue is credit-limited by buffer space; inst_* hold while valid && !ready.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);
  import cpu_defs::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] pc, inflight_pc, redirect_addr;
  logic            inflight_vld, pop, push, issue;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  fetch_entry_t    head, push_dat;

  assign redirect_addr = redirect_pc & PC_ALIGN;
  assign pop           = inst_valid && inst_ready;

  // Credits: buffered words plus the word still in the im pipe, less the one leaving now.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_vld} - {{CW{1'b0}}, pop};
  assign issue     = !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));

  assign im_addr = redirect_valid ? redirect_addr : pc;

  // A returning word is stale once a redirect arrives, so it never enters the buffer.
  assign push          = inflight_vld && !redirect_valid;
  assign push_dat.pc   = inflight_pc;
  assign push_dat.data = im_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC & PC_ALIGN;
      inflight_vld <= 1'b0;
      inflight_pc  <= '0;
    end else if (redirect_valid) begin
      pc           <= redirect_addr + PC_STEP;
      inflight_vld <= 1'b1;
      inflight_pc  <= redirect_addr;
    end else if (issue) begin
      pc           <= pc + PC_STEP;
      inflight_vld <= 1'b1;
      inflight_pc  <= pc;
    end else begin
      inflight_vld <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (count),
    .head     (head)
  );

  assign inst_valid = (count != '0);
  assign inst_pc    = head.pc;
  assign inst_data  = head.data;
endmodule

// File: tb/tb_if_fetch.sv
`timescale 1ns/1ps
// Directed bench for if_fetch against a registered-ROM instruction memory.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] im_addr;
  logic [31:0] im_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] BASE = 32'h9FC0_0000;

  if_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) im_data <= rom(im_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 after release (inputs may still be changed before sampling).
  task automatic start_reset(input logic rdy);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = rdy;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    tick();
    #1;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=00000000", inst_pc); end
    checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", inst_data); end
    checks++; if (im_addr !== BASE) begin failures++; $display("FAIL reset_addr got=%h exp=%h", im_addr, BASE); end
  endtask

  task automatic test_stream();
    logic [31:0] ea, ep;
    start_reset(1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      #1;
      ea = BASE + 32'(4 * c);
      checks++; if (im_addr !== ea) begin failures++; $display("FAIL stream_addr c=%0d got=%h exp=%h", c, im_addr, ea); end
      if (c < 2) begin
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid c=%0d got=%b exp=0", c, inst_valid); end
      end else begin
        ep = BASE + 32'(4 * (c - 2));
        checks++; if (inst_valid !== 1'b1 || inst_pc !== ep) begin failures++; $display("FAIL stream_pc c=%0d got=%b/%h exp=1/%h", c, inst_valid, inst_pc, ep); end
        checks++; if (inst_data !== rom(ep)) begin failures++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, inst_data, rom(ep)); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] ea, ep;
    start_reset(1'b0);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      inst_ready = (c >= 6);
      #1;
      if (c < 6) begin
        ea = (c < 2) ? BASE + 32'(4 * c) : BASE + 32'h8;
        checks++; if (im_addr !== ea) begin failures++; $display("FAIL stall_addr c=%0d got=%h exp=%h", c, im_addr, ea); end
        if (c >= 2) begin
          checks++; if (inst_valid !== 1'b1 || inst_pc !== BASE || inst_data !== rom(BASE)) begin
            failures++; $display("FAIL stall_hold c=%0d got=%b/%h/%h exp=1/%h/%h", c, inst_valid, inst_pc, inst_data, BASE, rom(BASE));
          end
        end
      end else begin
        ep = BASE + 32'(4 * (c - 6));
        checks++; if (inst_valid !== 1'b1 || inst_pc !== ep || inst_data !== rom(ep)) begin
          failures++; $display("FAIL stall_release c=%0d got=%b/%h/%h exp=1/%h/%h", c, inst_valid, inst_pc, inst_data, ep, rom(ep));
        end
      end
    end
  endtask

  task automatic test_redirect_full();
    logic [31:0] ep;
    start_reset(1'b0);
    repeat (4) tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    #1;
    checks++; if (im_addr !== 32'h8000_0200) begin failures++; $display("FAIL redir_addr got=%h exp=80000200", im_addr); end
    tick();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%b exp=0", inst_valid); end
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      ep = 32'h8000_0200 + 32'(4 * k);
      checks++; if (inst_valid !== 1'b1 || inst_pc !== ep || inst_data !== rom(ep)) begin
        failures++; $display("FAIL redir_stream k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, ep, rom(ep));
      end
    end
  endtask

  task automatic test_redirect_unaligned();
    start_reset(1'b1);
    repeat (4) tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0203;
    #1;
    checks++; if (im_addr !== 32'h8000_0200) begin failures++; $display("FAIL unal_addr got=%h exp=80000200", im_addr); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL unal_bubble got=%b exp=0", inst_valid); end
    tick();
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0200) begin failures++; $display("FAIL unal_pc got=%b/%h exp=1/80000200", inst_valid, inst_pc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ep;
    start_reset(1'b1);
    repeat (4) tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    #1;
    checks++; if (im_addr !== 32'h8000_0200) begin failures++; $display("FAIL b2b_addr1 got=%h exp=80000200", im_addr); end
    tick();
    redirect_pc = 32'h8000_0300;
    #1;
    checks++; if (im_addr !== 32'h8000_0300 || inst_valid !== 1'b0) begin failures++; $display("FAIL b2b_addr2 got=%h/%b exp=80000300/0", im_addr, inst_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL b2b_bubble got=%b exp=0", inst_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      ep = 32'h8000_0300 + 32'(4 * k);
      checks++; if (inst_valid !== 1'b1 || inst_pc !== ep || inst_data !== rom(ep)) begin
        failures++; $display("FAIL b2b_stream k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, ep, rom(ep));
      end
    end
  endtask

  task automatic test_wrap();
    start_reset(1'b1);
    repeat (3) tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    checks++; if (im_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", im_addr); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (im_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr1 got=%h exp=00000000", im_addr); end
    tick();
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc0 got=%b/%h exp=1/fffffffc", inst_valid, inst_pc); end
    tick();
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== rom(32'h0)) begin
      failures++; $display("FAIL wrap_pc1 got=%b/%h/%h exp=1/00000000/%h", inst_valid, inst_pc, inst_data, rom(32'h0));
    end
  endtask

  task automatic test_reset_mid();
    start_reset(1'b1);
    repeat (5) tick();
    #1;
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", inst_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0) begin failures++; $display("FAIL mid_async got=%b/%h exp=0/00000000", inst_valid, inst_pc); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (im_addr !== BASE || inst_valid !== 1'b0) begin failures++; $display("FAIL mid_restart_addr got=%h/%b exp=%h/0", im_addr, inst_valid, BASE); end
    tick();
    tick();
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== BASE || inst_data !== rom(BASE)) begin
      failures++; $display("FAIL mid_restart_pc got=%b/%h/%h exp=1/%h/%h", inst_valid, inst_pc, inst_data, BASE, rom(BASE));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_unaligned();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
